// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: issues stall codes and per-register enable/flush strobes for the 5-stage pipeline; PIPE_HAZARD_PERF_EN adds perf counters.
// Latency: stall/enable/flush are combinational from state and inputs; halt and counters update on the next CLK edge.
// Backpressure: a data miss holds IF..EX and bubbles MEM|WB until dhit; halt freezes every register until RST.
module pipe_hazard_ctrl #(
    parameter int WAIT_CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ihit,
    input  logic                  dhit,
    input  logic [4:0]            ifid_rs,
    input  logic [4:0]            ifid_rt,
    input  logic                  idex_DataRead,
    input  logic [4:0]            idex_rt,
    input  logic                  exmem_DataRead,
    input  logic                  exmem_DataWrite,
    input  logic                  exmem_redirect,
    input  logic                  exmem_Halt,
    output logic [2:0]            stall,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic                  halt,
    output logic [WAIT_CNT_W-1:0] dwait_cycles
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_loaduse,
    output logic [31:0]           perf_iwait,
    output logic [31:0]           perf_flush
`endif
);

    typedef enum logic [2:0] {
        NO_STALL    = 3'd0,
        IFID_STALL  = 3'd1,
        IDEX_STALL  = 3'd2,
        EXMEM_STALL = 3'd3,
        FULL_STALL  = 3'd4
    } pipe_stall_t;

    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

    typedef enum logic [2:0] {C_HALT, C_DMISS, C_REDIR, C_LOADUSE, C_IMISS, C_NONE} hz_case_t;

    state_t                state_q, state_d;
    logic                  halt_q, halt_d;
    logic [WAIT_CNT_W-1:0] dwait_q, dwait_d;
    hz_case_t              hz;
    pipe_stall_t           stall_code;
    logic                  memop;
    logic                  loaduse;

    assign memop   = exmem_DataRead | exmem_DataWrite;
    assign loaduse = idex_DataRead & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    // Priority encode the hazard; first match wins.
    always_comb begin
        hz = C_NONE;
        if (exmem_Halt && !memop)  hz = C_HALT;
        else if (memop && !dhit)   hz = C_DMISS;
        else if (exmem_redirect)   hz = C_REDIR;
        else if (loaduse)          hz = C_LOADUSE;
        else if (!ihit)            hz = C_IMISS;
    end

    always_comb begin
        state_d     = RUN;
        halt_d      = halt_q;
        stall_code  = NO_STALL;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (RST) begin
            stall_code  = FULL_STALL;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (state_q == HALTED) begin
            state_d    = HALTED;
            halt_d     = 1'b1;
            stall_code = FULL_STALL;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
        end else begin
            case (hz)
                C_HALT: begin
                    state_d    = HALTED;
                    halt_d     = 1'b1;
                    stall_code = FULL_STALL;
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    exmem_en   = 1'b0;
                    memwb_en   = 1'b0;
                end
                C_DMISS: begin
                    state_d     = DWAIT;
                    stall_code  = EXMEM_STALL;
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                end
                C_REDIR: begin
                    // The branch target loads even if the current fetch has not returned.
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end
                C_LOADUSE: begin
                    stall_code = IDEX_STALL;
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
                C_IMISS: begin
                    stall_code = IFID_STALL;
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dwait_d = dwait_q;
        if (state_q == DWAIT && dwait_q != '1) dwait_d = dwait_q + WAIT_CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
            dwait_q <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            dwait_q <= dwait_d;
        end
    end

    assign stall        = stall_code;
    assign halt         = halt_q;
    assign dwait_cycles = dwait_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_loaduse_q, perf_loaduse_d;
    logic [31:0] perf_iwait_q, perf_iwait_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_loaduse_d = perf_loaduse_q;
        perf_iwait_d   = perf_iwait_q;
        perf_flush_d   = perf_flush_q;
        if (state_q != HALTED) begin
            if (hz == C_LOADUSE && perf_loaduse_q != '1) perf_loaduse_d = perf_loaduse_q + 32'd1;
            if (hz == C_IMISS && perf_iwait_q != '1)     perf_iwait_d   = perf_iwait_q + 32'd1;
            if (hz == C_REDIR && perf_flush_q != '1)     perf_flush_d   = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_loaduse_q <= '0;
            perf_iwait_q   <= '0;
            perf_flush_q   <= '0;
        end else begin
            perf_loaduse_q <= perf_loaduse_d;
            perf_iwait_q   <= perf_iwait_d;
            perf_flush_q   <= perf_flush_d;
        end
    end

    assign perf_loaduse = perf_loaduse_q;
    assign perf_iwait   = perf_iwait_q;
    assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: expected output vectors are queued as stimulus is applied and popped at the following negedge.
module tb_pipe_hazard_ctrl;
    localparam int WAIT_CNT_W = 16;

    // Vector layout: {stall[2:0], pc_en, en{ifid,idex,exmem,memwb}, flush{ifid,idex,exmem,memwb}, halt}
    localparam logic [12:0] V_RST = {3'd4, 1'b0, 4'b0000, 4'b1111, 1'b0};
    localparam logic [12:0] V_RUN = {3'd0, 1'b1, 4'b1111, 4'b0000, 1'b0};
    localparam logic [12:0] V_LU  = {3'd2, 1'b0, 4'b0111, 4'b0100, 1'b0};
    localparam logic [12:0] V_DM  = {3'd3, 1'b0, 4'b0001, 4'b0001, 1'b0};
    localparam logic [12:0] V_RD  = {3'd0, 1'b1, 4'b1111, 4'b1110, 1'b0};
    localparam logic [12:0] V_IM  = {3'd1, 1'b0, 4'b1111, 4'b1000, 1'b0};
    localparam logic [12:0] V_HC  = {3'd4, 1'b0, 4'b0000, 4'b0000, 1'b0};
    localparam logic [12:0] V_HD  = {3'd4, 1'b0, 4'b0000, 4'b0000, 1'b1};

    logic CLK = 1'b0;
    logic RST;
    logic ihit, dhit;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic idex_DataRead, exmem_DataRead, exmem_DataWrite, exmem_redirect, exmem_Halt;
    logic [2:0] stall;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
    logic [WAIT_CNT_W-1:0] dwait_cycles;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_loaduse, perf_iwait, perf_flush;
`endif

    typedef struct packed {
        logic [12:0]           v;
        logic                  dw_chk;
        logic [WAIT_CNT_W-1:0] dw;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.WAIT_CNT_W(WAIT_CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_DataRead(idex_DataRead), .idex_rt(idex_rt),
        .exmem_DataRead(exmem_DataRead), .exmem_DataWrite(exmem_DataWrite),
        .exmem_redirect(exmem_redirect), .exmem_Halt(exmem_Halt),
        .stall(stall), .pc_en(pc_en),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .dwait_cycles(dwait_cycles)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_loaduse(perf_loaduse), .perf_iwait(perf_iwait), .perf_flush(perf_flush)
`endif
    );

    function automatic logic [12:0] obs();
        return {stall, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};
    endfunction

    function automatic void push(input string nm, input logic [12:0] v,
                                 input logic c, input logic [WAIT_CNT_W-1:0] dw);
        exp_t e;
        e.v = v;
        e.dw_chk = c;
        e.dw = dw;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endfunction

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0;
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
        idex_DataRead = 1'b0; exmem_DataRead = 1'b0; exmem_DataWrite = 1'b0;
        exmem_redirect = 1'b0; exmem_Halt = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        string nm;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            idle();
            case (i)
                0: begin RST = 1'b1; push("rst_hold", V_RST, 1'b1, '0); end
                1: begin
                    RST = 1'b1; exmem_Halt = 1'b1; exmem_DataRead = 1'b1;
                    idex_DataRead = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
                    push("rst_hold_hazards", V_RST, 1'b1, '0);
                end
                default: begin RST = 1'b0; push("rst_release", V_RUN, 1'b1, '0); end
            endcase
            @(negedge CLK);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            total++;
            if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", nm, obs(), e.v); end
            if (e.dw_chk) begin
                total++;
                if (dwait_cycles !== e.dw) begin bad++; $display("FAIL %s dwait: got %0d want %0d", nm, dwait_cycles, e.dw); end
            end
        end
    endtask

    task automatic test_loaduse();
        exp_t e;
        string nm;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            idle();
            idex_DataRead = 1'b1;
            case (i)
                0: begin idex_rt = 5'd5; ifid_rs = 5'd5; push("lu_rs", V_LU, 1'b0, '0); end
                1: begin idex_rt = 5'd0; ifid_rs = 5'd0; push("lu_r0", V_RUN, 1'b0, '0); end
                2: begin idex_rt = 5'd9; ifid_rt = 5'd9; ifid_rs = 5'd1; push("lu_rt", V_LU, 1'b0, '0); end
                3: begin idex_rt = 5'd31; ifid_rt = 5'd31; push("lu_r31", V_LU, 1'b0, '0); end
                4: begin idex_rt = 5'd5; ifid_rs = 5'd4; ifid_rt = 5'd6; push("lu_nomatch", V_RUN, 1'b0, '0); end
                default: begin idex_DataRead = 1'b0; idex_rt = 5'd5; ifid_rs = 5'd5; push("lu_noload", V_RUN, 1'b1, '0); end
            endcase
            @(negedge CLK);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            total++;
            if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", nm, obs(), e.v); end
            if (e.dw_chk) begin
                total++;
                if (dwait_cycles !== e.dw) begin bad++; $display("FAIL %s dwait: got %0d want %0d", nm, dwait_cycles, e.dw); end
            end
        end
    endtask

    task automatic test_dwait();
        exp_t e;
        string nm;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            idle();
            case (i)
                0: begin exmem_DataRead = 1'b1; push("dw_miss0", V_DM, 1'b1, 16'd0); end
                1: begin exmem_DataRead = 1'b1; push("dw_miss1", V_DM, 1'b1, 16'd0); end
                2: begin exmem_DataRead = 1'b1; push("dw_miss2", V_DM, 1'b1, 16'd1); end
                3: begin exmem_DataRead = 1'b1; dhit = 1'b1; push("dw_hit", V_RUN, 1'b1, 16'd2); end
                4: push("dw_after", V_RUN, 1'b1, 16'd3);
                5: begin exmem_DataWrite = 1'b1; push("dw_st_miss", V_DM, 1'b1, 16'd3); end
                6: begin exmem_DataWrite = 1'b1; dhit = 1'b1; ihit = 1'b0; push("dw_hit_imiss", V_IM, 1'b1, 16'd3); end
                default: push("dw_after2", V_RUN, 1'b1, 16'd4);
            endcase
            @(negedge CLK);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            total++;
            if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", nm, obs(), e.v); end
            if (e.dw_chk) begin
                total++;
                if (dwait_cycles !== e.dw) begin bad++; $display("FAIL %s dwait: got %0d want %0d", nm, dwait_cycles, e.dw); end
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        string nm;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            idle();
            case (i)
                0: begin
                    exmem_redirect = 1'b1; ihit = 1'b0;
                    idex_DataRead = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7;
                    push("pr_redir_lu_imiss", V_RD, 1'b1, 16'd4);
                end
                1: begin exmem_redirect = 1'b1; exmem_DataRead = 1'b1; push("pr_dmiss_redir", V_DM, 1'b1, 16'd4); end
                2: begin
                    exmem_redirect = 1'b1; exmem_DataRead = 1'b1; dhit = 1'b1; ihit = 1'b0;
                    push("pr_hit_redir", V_RD, 1'b1, 16'd4);
                end
                3: push("pr_idle", V_RUN, 1'b1, 16'd5);
                4: begin ihit = 1'b0; idex_DataRead = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2; push("pr_lu_imiss", V_LU, 1'b0, '0); end
                default: begin ihit = 1'b0; push("pr_imiss", V_IM, 1'b0, '0); end
            endcase
            @(negedge CLK);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            total++;
            if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", nm, obs(), e.v); end
            if (e.dw_chk) begin
                total++;
                if (dwait_cycles !== e.dw) begin bad++; $display("FAIL %s dwait: got %0d want %0d", nm, dwait_cycles, e.dw); end
            end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        string nm;
        logic [31:0] r;
        for (int i = 0; i < 13; i++) begin
            @(posedge CLK); #1;
            idle();
            if (i == 0) begin
                exmem_Halt = 1'b1;
                push("hl_enter", V_HC, 1'b1, 16'd5);
            end else if (i <= 10) begin
                r = $urandom;
                ihit = r[0]; dhit = r[1]; exmem_DataRead = r[2]; exmem_DataWrite = r[3];
                exmem_redirect = r[4]; exmem_Halt = r[5]; idex_DataRead = r[6];
                idex_rt = r[11:7]; ifid_rs = r[11:7]; ifid_rt = r[16:12];
                push("hl_held", V_HD, 1'b1, 16'd5);
            end else if (i == 11) begin
                RST = 1'b1;
                push("hl_rst", V_RST, 1'b1, '0);
            end else begin
                RST = 1'b0;
                push("hl_run", V_RUN, 1'b1, '0);
            end
            @(negedge CLK);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            total++;
            if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", nm, obs(), e.v); end
            if (e.dw_chk) begin
                total++;
                if (dwait_cycles !== e.dw) begin bad++; $display("FAIL %s dwait: got %0d want %0d", nm, dwait_cycles, e.dw); end
            end
        end
    endtask

    task automatic test_halt_store();
        exp_t e;
        string nm;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            idle();
            case (i)
                0: begin exmem_Halt = 1'b1; exmem_DataWrite = 1'b1; push("hs_miss", V_DM, 1'b1, 16'd0); end
                1: begin exmem_Halt = 1'b1; exmem_DataWrite = 1'b1; dhit = 1'b1; push("hs_hit", V_RUN, 1'b1, 16'd0); end
                2: begin exmem_Halt = 1'b1; push("hs_enter", V_HC, 1'b1, 16'd1); end
                default: push("hs_held", V_HD, 1'b1, 16'd1);
            endcase
            @(negedge CLK);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            total++;
            if (obs() !== e.v) begin bad++; $display("FAIL %s: got %b want %b", nm, obs(), e.v); end
            if (e.dw_chk) begin
                total++;
                if (dwait_cycles !== e.dw) begin bad++; $display("FAIL %s dwait: got %0d want %0d", nm, dwait_cycles, e.dw); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        idle();
        test_reset();
        test_loaduse();
        test_dwait();
        test_priority();
        test_halt();
        test_halt_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
